// File: rtl/sq_wave_seq.sv
// sq_wave_seq: square-wave step sequencer.
//   Plays a 4-step {level, len} pattern table on the q / sq_c2 / sq_i
//   waveform interface. Each step lasts len+1 cycles. Playback repeats for a
//   loop count latched on start, where 0 means play continuously. A one-cycle
//   done pulse follows normal completion.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   cfg_we/addr/level/len  pattern-table write port (ignored while busy)
//   start, loops           begin playback (IDLE only), loop count
//   stop                   abort playback (RUN only), no done pulse
//   busy, done             in RUN / one-cycle completion pulse
//   q, sq_c2, sq_i         waveform level, in-step counter, step index
module sq_wave_seq #(
   parameter int CNT_W  = 5,
   parameter int LOOP_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [1:0]        cfg_addr,
   input  logic              cfg_level,
   input  logic [CNT_W-1:0]  cfg_len,
   input  logic              start,
   input  logic [LOOP_W-1:0] loops,
   input  logic              stop,
   output logic              busy,
   output logic              done,
   output logic              q,
   output logic [CNT_W-1:0]  sq_c2,
   output logic [1:0]        sq_i
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic                r_level [4];
   logic [CNT_W-1:0]    r_len   [4];
   logic [CNT_W-1:0]    r_sq_c2;
   logic [1:0]          r_sq_i;
   logic [LOOP_W-1:0]   r_loop_rem;

   logic                w_step_end;
   logic                w_loop_end;
   logic                w_last_loop;

   // loop_rem never reaches 0 during a counted run (DONE is taken at 1),
   // so loop_rem==0 while running identifies continuous mode.
   always_comb begin
      w_step_end  = (r_sq_c2 == r_len[r_sq_i]);
      w_loop_end  = w_step_end && (r_sq_i == 2'd3);
      w_last_loop = w_loop_end && (r_loop_rem == LOOP_W'(1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_RUN;
         S_RUN: begin
            // stop takes priority over a simultaneous final loop end
            if (stop)             w_state_nxt = S_IDLE;
            else if (w_last_loop) w_state_nxt = S_DONE;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Pattern table: writes accepted whenever not playing, including the
   // start edge itself, so such a write applies to the run being started.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < 4; k++) begin
            r_level[k] <= 1'b0;
            r_len[k]   <= '0;
         end
      end else if (cfg_we && (r_state != S_RUN)) begin
         r_level[cfg_addr] <= cfg_level;
         r_len[cfg_addr]   <= cfg_len;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sq_c2    <= '0;
         r_sq_i     <= '0;
         r_loop_rem <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_sq_c2 <= '0;
               r_sq_i  <= '0;
               if (start) r_loop_rem <= loops;
            end
            S_RUN: begin
               if (stop || w_last_loop) begin
                  r_sq_c2 <= '0;
                  r_sq_i  <= '0;
               end else if (w_step_end) begin
                  r_sq_c2 <= '0;
                  r_sq_i  <= r_sq_i + 2'd1;
                  if (w_loop_end && (r_loop_rem != '0))
                     r_loop_rem <= r_loop_rem - LOOP_W'(1);
               end else begin
                  r_sq_c2 <= r_sq_c2 + CNT_W'(1);
               end
            end
            default: begin
               r_sq_c2 <= '0;
               r_sq_i  <= '0;
            end
         endcase
      end
   end

   // Outputs depend on registers only; counters are held at 0 outside RUN.
   always_comb begin
      busy  = (r_state == S_RUN);
      done  = (r_state == S_DONE);
      q     = (r_state == S_RUN) && r_level[r_sq_i];
      sq_c2 = r_sq_c2;
      sq_i  = r_sq_i;
   end

endmodule

// File: tb/tb_sq_wave_seq.sv
module tb_sq_wave_seq;

   logic       clk;
   logic       rst_n;
   logic       cfg_we;
   logic [1:0] cfg_addr;
   logic       cfg_level;
   logic [4:0] cfg_len;
   logic       start;
   logic [3:0] loops;
   logic       stop;
   logic       busy;
   logic       done;
   logic       q;
   logic [4:0] sq_c2;
   logic [1:0] sq_i;

   int n_checks = 0;
   int n_errors = 0;

   int m_lvl [4];
   int m_len [4];

   typedef struct {
      logic       we;
      logic [1:0] addr;
      logic       lvl;
      logic [4:0] len;
      logic       st;
      logic [3:0] lp;
      logic       sp;
      logic       e_busy;
      logic       e_done;
      logic       e_q;
      logic [4:0] e_c2;
      logic [1:0] e_i;
   } vec_t;

   vec_t vecs [11];

   sq_wave_seq #(.CNT_W(5), .LOOP_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_level (cfg_level),
      .cfg_len   (cfg_len),
      .start     (start),
      .loops     (loops),
      .stop      (stop),
      .busy      (busy),
      .done      (done),
      .q         (q),
      .sq_c2     (sq_c2),
      .sq_i      (sq_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input int eb, input int ed, input int eq,
                          input int ec, input int ei);
      chk({tag, ".busy"},  busy,  eb);
      chk({tag, ".done"},  done,  ed);
      chk({tag, ".q"},     q,     eq);
      chk({tag, ".sq_c2"}, sq_c2, ec);
      chk({tag, ".sq_i"},  sq_i,  ei);
   endtask

   task automatic wr(input int a, input int lv, input int ln);
      cfg_we = 1'b1; cfg_addr = 2'(a); cfg_level = lv[0]; cfg_len = 5'(ln);
      tick();
      cfg_we = 1'b0;
      m_lvl[a] = lv;
      m_len[a] = ln;
   endtask

   // start edge, optionally with a table write on the same edge
   task automatic launch(input int lp, input int wa, input int wl, input int wn);
      start = 1'b1; loops = 4'(lp);
      if (wa >= 0) begin
         cfg_we = 1'b1; cfg_addr = 2'(wa); cfg_level = wl[0]; cfg_len = 5'(wn);
         m_lvl[wa] = wl;
         m_len[wa] = wn;
      end
      tick();
      start = 1'b0; cfg_we = 1'b0;
   endtask

   // Checks ncyc RUN cycles against the bench pattern model. Optional
   // disturbances: ignored table write, ignored start, stop at given cycle.
   task automatic play(input string tag, input int ncyc, input int wr_at,
                       input int start_at, input int stop_at);
      int p, pos, k;
      p = 0;
      for (int j = 0; j < 4; j++) p += m_len[j] + 1;
      for (int t = 0; t < ncyc; t++) begin
         pos = t % p;
         k = 0;
         while (pos > m_len[k]) begin
            pos -= m_len[k] + 1;
            k++;
         end
         chk_all(tag, 1, 0, m_lvl[k], pos, k);
         if (t == wr_at) begin
            cfg_we = 1'b1; cfg_addr = 2'd0; cfg_level = 1'b0; cfg_len = 5'd7;
         end
         if (t == start_at) begin
            start = 1'b1; loops = 4'd3;
         end
         if (t == stop_at) stop = 1'b1;
         tick();
         cfg_we = 1'b0; start = 1'b0; stop = 1'b0;
      end
      if (stop_at >= 0) begin
         chk_all({tag, ".stopped"}, 0, 0, 0, 0, 0);
         tick();
         chk_all({tag, ".after"}, 0, 0, 0, 0, 0);
      end else begin
         chk_all({tag, ".donecyc"}, 0, 1, 0, 0, 0);
         tick();
         chk_all({tag, ".idle"}, 0, 0, 0, 0, 0);
      end
   endtask

   initial begin
      rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_level = 1'b0; cfg_len = '0;
      start = 1'b0; loops = '0; stop = 1'b0;
      for (int j = 0; j < 4; j++) begin m_lvl[j] = 0; m_len[j] = 0; end

      //            we addr lvl len  st lp sp  busy done q c2 i
      vecs[0]  = '{1'b0, 2'd0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0};
      vecs[1]  = '{1'b0, 2'd0, 1'b0, 5'd0, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0};
      vecs[2]  = '{1'b0, 2'd0, 1'b0, 5'd0, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 2'd1};
      vecs[3]  = '{1'b0, 2'd0, 1'b0, 5'd0, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 2'd2};
      vecs[4]  = '{1'b0, 2'd0, 1'b0, 5'd0, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 2'd3};
      vecs[5]  = '{1'b0, 2'd0, 1'b0, 5'd0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 2'd0};
      vecs[6]  = '{1'b0, 2'd0, 1'b0, 5'd0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0};
      vecs[7]  = '{1'b1, 2'd0, 1'b1, 5'd4, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0};
      vecs[8]  = '{1'b1, 2'd1, 1'b0, 5'd4, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0};
      vecs[9]  = '{1'b1, 2'd2, 1'b1, 5'd9, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0};
      vecs[10] = '{1'b1, 2'd3, 1'b0, 5'd9, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0};

      #2;
      chk_all("reset", 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;

      // default-table single loop, then pattern programming
      for (int v = 0; v < 11; v++) begin
         cfg_we = vecs[v].we; cfg_addr = vecs[v].addr; cfg_level = vecs[v].lvl;
         cfg_len = vecs[v].len; start = vecs[v].st; loops = vecs[v].lp; stop = vecs[v].sp;
         tick();
         chk($sformatf("vec%0d.busy", v), busy, vecs[v].e_busy);
         chk($sformatf("vec%0d.done", v), done, vecs[v].e_done);
         chk($sformatf("vec%0d.q", v), q, vecs[v].e_q);
         chk($sformatf("vec%0d.sq_c2", v), sq_c2, vecs[v].e_c2);
         chk($sformatf("vec%0d.sq_i", v), sq_i, vecs[v].e_i);
      end
      cfg_we = 1'b0; stop = 1'b0;
      m_lvl[0] = 1; m_lvl[1] = 0; m_lvl[2] = 1; m_lvl[3] = 0;
      m_len[0] = 4; m_len[1] = 4; m_len[2] = 9; m_len[3] = 9;

      // two loops of 30 cycles
      launch(2, -1, 0, 0);
      play("two_loops", 60, -1, -1, -1);

      // write during RUN is ignored
      launch(2, -1, 0, 0);
      play("busy_write", 60, 2, -1, -1);

      // same write in IDLE takes effect; write on start edge also applies
      wr(0, 1, 7);
      launch(1, 1, 1, 2);
      play("after_write", 8 + 3 + 10 + 10, -1, -1, -1);

      // continuous mode then stop
      wr(0, 1, 1); wr(1, 0, 1); wr(2, 1, 1); wr(3, 0, 1);
      launch(0, -1, 0, 0);
      play("continuous", 120, -1, -1, 119);

      // stop on final loop end, start during RUN ignored
      launch(1, -1, 0, 0);
      play("stop_last", 8, -1, 3, 7);

      // asynchronous reset mid-step
      wr(0, 1, 4); wr(1, 0, 4); wr(2, 1, 9); wr(3, 0, 9);
      launch(1, -1, 0, 0);
      repeat (3) tick();
      chk_all("pre_reset", 1, 0, 1, 3, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("async_reset", 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int j = 0; j < 4; j++) begin m_lvl[j] = 0; m_len[j] = 0; end
      @(posedge clk); #1;
      launch(1, -1, 0, 0);
      play("cleared", 4, -1, -1, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
